// File: rtl/digit_serial_adder_if.sv
// Request/response bundle for the digit-serial adder: operands and start in,
// busy/done handshake and registered result out.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, c0, input busy, done, s, cout, ovf);
  modport slave  (input start, sub, a, b, c0, output busy, done, s, cout, ovf);
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through one short ripple chain,
// carry held in a flop between digits. IDLE -> RUN (N cycles) -> DONE (1 cycle).
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  digit_serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] a_r, b_r, a_nxt, b_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] s_r;
  logic             cout_r, ovf_r;

  assign sum  = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign last = (cnt == CW'(N - 1));

  // A doubles as the result register: digits leave at the LSB and sums enter at the MSB,
  // so after N digits it holds the full result.
  generate
    if (N == 1) begin : g_single
      assign a_nxt = sum[DIGIT-1:0];
      assign b_nxt = '0;
    end else begin : g_multi
      assign a_nxt = {sum[DIGIT-1:0], a_r[WIDTH-1:DIGIT]};
      assign b_nxt = b_r >> DIGIT;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_r   <= bus.a;
      b_r   <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? 1'b1 : bus.c0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_r   <= a_nxt;
      b_r   <= b_nxt;
      carry <= sum[DIGIT];
      cnt   <= cnt + CW'(1);
      if (last) begin
        s_r    <= a_nxt;
        cout_r <= sum[DIGIT];
        // carry into the MSB recovered as a^b^sum at that bit
        ovf_r  <= sum[DIGIT] ^ (a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ sum[DIGIT-1]);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed handshake scenarios on WIDTH=8/DIGIT=2, random
// operations, and an exhaustive WIDTH=4 sweep over DIGIT=1,2,4 against an integer model.
module tb_digit_serial_adder;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  digit_serial_adder_if #(.WIDTH(8)) bus8();
  digit_serial_adder_if #(.WIDTH(4)) bus_d1();
  digit_serial_adder_if #(.WIDTH(4)) bus_d2();
  digit_serial_adder_if #(.WIDTH(4)) bus_d4();

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (.clk(clk), .rst(rst), .bus(bus8));
  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_d1  (.clk(clk), .rst(rst), .bus(bus_d1));
  digit_serial_adder #(.WIDTH(4), .DIGIT(2)) u_d2  (.clk(clk), .rst(rst), .bus(bus_d2));
  digit_serial_adder #(.WIDTH(4), .DIGIT(4)) u_d4  (.clk(clk), .rst(rst), .bus(bus_d4));

  // the three WIDTH=4 instances share one stimulus
  logic       w4_start, w4_sub, w4_c0;
  logic [3:0] w4_a, w4_b;
  assign bus_d1.start = w4_start; assign bus_d2.start = w4_start; assign bus_d4.start = w4_start;
  assign bus_d1.sub   = w4_sub;   assign bus_d2.sub   = w4_sub;   assign bus_d4.sub   = w4_sub;
  assign bus_d1.c0    = w4_c0;    assign bus_d2.c0    = w4_c0;    assign bus_d4.c0    = w4_c0;
  assign bus_d1.a     = w4_a;     assign bus_d2.a     = w4_a;     assign bus_d4.a     = w4_a;
  assign bus_d1.b     = w4_b;     assign bus_d2.b     = w4_b;     assign bus_d4.b     = w4_b;

  logic [2:0] w4_done;
  logic [3:0] w4_s [3];
  logic [2:0] w4_cout, w4_ovf;
  assign w4_done = {bus_d4.done, bus_d2.done, bus_d1.done};
  assign w4_cout = {bus_d4.cout, bus_d2.cout, bus_d1.cout};
  assign w4_ovf  = {bus_d4.ovf,  bus_d2.ovf,  bus_d1.ovf};
  assign w4_s[0] = bus_d1.s;
  assign w4_s[1] = bus_d2.s;
  assign w4_s[2] = bus_d4.s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {ovf, cout, s} from plain integer arithmetic; s in the low w bits
  function automatic logic [9:0] model(int w, int a, int b, bit c0, bit sub);
    int mask, half, sa, sb, u, t;
    logic [9:0] r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    if (sub) begin
      u = a + ((~b) & mask) + 1;
      t = sa - sb;
    end else begin
      u = a + b + int'(c0);
      t = sa + sb + int'(c0);
    end
    r = '0;
    r[7:0] = 8'(u & mask);
    r[8]   = ((u >> w) & 1) != 0;
    r[9]   = (t > half - 1) || (t < -half);
    return r;
  endfunction

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input bit c0, input bit sub);
    @(posedge clk); #1;
    bus8.a = a; bus8.b = b; bus8.c0 = c0; bus8.sub = sub; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  // returns at the negedge where done is seen; lat counts negedges after the accepting edge
  task automatic wait_done(output int lat, output int busy_n, output bit ok);
    lat = 0; busy_n = 0; ok = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin ok = 1'b1; break; end
      if (bus8.busy === 1'b1) busy_n++;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [9:0] exp, input int lat, input bit ok);
    checks++;
    if (!ok || lat !== 4) begin
      errors++; $display("FAIL %s latency got %0d ok=%0d exp 4", name, lat, ok);
    end
    checks++;
    if ({bus8.ovf, bus8.cout, bus8.s} !== exp) begin
      errors++;
      $display("FAIL %s result got s=%h cout=%b ovf=%b exp s=%h cout=%b ovf=%b",
               name, bus8.s, bus8.cout, bus8.ovf, exp[7:0], exp[8], exp[9]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.c0 = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b s=%h cout=%b ovf=%b exp all 0",
               bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.ovf);
    end
    #1; rst = 1'b0; bus8.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++; $display("FAIL reset_wins_start busy got %b exp 0", bus8.busy);
    end
  endtask

  task automatic test_basic();
    int lat, busy_n; bit ok;
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat, busy_n, ok);
    check_op("t1_ff_plus_01", 10'b01_0000_0000, lat, ok);
    checks++;
    if (busy_n !== 4) begin errors++; $display("FAIL t1_busy_cycles got %0d exp 4", busy_n); end
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0) begin errors++; $display("FAIL t1_done_one_cycle got %b exp 0", bus8.done); end

    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(lat, busy_n, ok);
    check_op("t2_add_ovf", {1'b1, 1'b0, 8'h80}, lat, ok);
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(lat, busy_n, ok);
    check_op("t2_sub_ovf", {1'b1, 1'b1, 8'h7F}, lat, ok);
    start_op(8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(lat, busy_n, ok);
    check_op("t3_sub_c0_ignored", {1'b0, 1'b0, 8'hFE}, lat, ok);
  endtask

  task automatic test_back_to_back();
    int lat, busy_n; bit ok;
    logic [7:0] a2, b2;
    a2 = 8'($urandom); b2 = 8'($urandom);
    start_op(8'h33, 8'h44, 1'b0, 1'b0);
    wait_done(lat, busy_n, ok);
    check_op("b2b_first", model(8, 8'h33, 8'h44, 1'b0, 1'b0), lat, ok);
    // start held during DONE: accepted at the edge that leaves DONE
    bus8.a = a2; bus8.b = b2; bus8.c0 = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1; bus8.start = 1'b0;
    wait_done(lat, busy_n, ok);
    check_op("b2b_second", model(8, int'(a2), int'(b2), 1'b1, 1'b0), lat, ok);
  endtask

  task automatic test_start_while_busy();
    int dcount;
    logic [9:0] got;
    dcount = 0; got = '0;
    start_op(8'h12, 8'hF0, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin dcount++; got = {bus8.ovf, bus8.cout, bus8.s}; end
      if (j < 3) begin
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom); bus8.start = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
    end
    checks++;
    if (dcount !== 1) begin errors++; $display("FAIL t4_done_count got %0d exp 1", dcount); end
    checks++;
    if (got !== model(8, 8'h12, 8'hF0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL t4_result got %h exp %h", got, model(8, 8'h12, 8'hF0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, busy_n, dcount; bit ok;
    start_op(8'hA5, 8'h3C, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done, bus8.s} !== 10'h000) begin
      errors++; $display("FAIL t5_abort got busy=%b done=%b s=%h exp 0 0 00", bus8.busy, bus8.done, bus8.s);
    end
    dcount = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) dcount++;
    end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL t5_no_done got %0d exp 0", dcount); end
    start_op(8'hA5, 8'h3C, 1'b0, 1'b0);
    wait_done(lat, busy_n, ok);
    check_op("t5_after_reset", model(8, 8'hA5, 8'h3C, 1'b0, 1'b0), lat, ok);
    // reset during DONE clears the registered result
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus8.done, bus8.s, bus8.cout, bus8.ovf} !== 11'h000) begin
      errors++; $display("FAIL rst_in_done got done=%b s=%h cout=%b ovf=%b exp 0", bus8.done, bus8.s, bus8.cout, bus8.ovf);
    end
  endtask

  task automatic test_random();
    int lat, busy_n; bit ok;
    logic [7:0] a, b; bit c0, sub;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); c0 = 1'($urandom); sub = 1'($urandom);
      start_op(a, b, c0, sub);
      wait_done(lat, busy_n, ok);
      check_op("random", model(8, int'(a), int'(b), c0, sub), lat, ok);
    end
  endtask

  task automatic test_exhaustive_w4();
    int n_exp [3] = '{4, 2, 1};
    int lat [3];
    bit seen [3];
    logic [9:0] got [3];
    logic [9:0] exp;
    for (int code = 0; code < 1024; code++) begin
      @(posedge clk); #1;
      w4_a = 4'(code); w4_b = 4'(code >> 4); w4_c0 = 1'(code >> 8); w4_sub = 1'(code >> 9);
      w4_start = 1'b1;
      @(posedge clk); #1;
      w4_start = 1'b0;
      for (int i = 0; i < 3; i++) begin seen[i] = 1'b0; lat[i] = -1; got[i] = '0; end
      for (int j = 0; j < 7; j++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++)
          if (w4_done[i] === 1'b1 && !seen[i]) begin
            seen[i] = 1'b1; lat[i] = j;
            got[i] = {w4_ovf[i], w4_cout[i], 4'b0000, w4_s[i]};
          end
      end
      exp = model(4, int'(w4_a), int'(w4_b), w4_c0, w4_sub);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (lat[i] !== n_exp[i]) begin
          errors++; $display("FAIL w4_latency inst=%0d code=%0d got %0d exp %0d", i, code, lat[i], n_exp[i]);
        end
        checks++;
        if (got[i] !== exp) begin
          errors++; $display("FAIL w4_result inst=%0d code=%0d got %h exp %h", i, code, got[i], exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c0 = 1'b0;
    w4_start = 1'b0; w4_sub = 1'b0; w4_a = '0; w4_b = '0; w4_c0 = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    test_exhaustive_w4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
